// File: rtl/mul_iter.sv
// Iterative RV32M multiplier (MUL/MULH/MULHU/MULHSU), BITS_PER_CYCLE multiplier
// bits retired per cycle, valid/ready on both sides, kill for pipeline flush.
module mul_iter #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] operand_a_i,
  input  logic [WIDTH-1:0] operand_b_i,
  input  logic [1:0]       func_i,
  input  logic             kill_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic             busy_o
);

  localparam int N     = WIDTH / BITS_PER_CYCLE;
  localparam int CNT_W = $clog2(N + 1);
  localparam int PW    = 2 * WIDTH;

  if (WIDTH < 8 || (WIDTH % 2) != 0 || (WIDTH % BITS_PER_CYCLE) != 0 ||
      !(BITS_PER_CYCLE == 1 || BITS_PER_CYCLE == 2 ||
        BITS_PER_CYCLE == 4 || BITS_PER_CYCLE == 8)) begin : g_param_check
    $error("mul_iter: illegal WIDTH/BITS_PER_CYCLE combination");
  end

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;
  typedef enum logic [1:0] {
    FN_MUL    = 2'b00,
    FN_MULH   = 2'b01,
    FN_MULHU  = 2'b10,
    FN_MULHSU = 2'b11
  } func_e;

  state_e           state_q, state_d;
  func_e            func_q;
  logic             neg_q;
  logic [WIDTH-1:0] a_mag_q, b_mag_q, result_q;
  logic [PW-1:0]    product_q;
  logic [CNT_W-1:0] count_q;

  logic             sign_a, sign_b, last_iter;
  logic [PW-1:0]    partial, addend, final_prod;

  assign last_iter = (count_q == CNT_W'(N - 1));

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    state_d = state_q;
    if (kill_i) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (valid_i)   state_d = CALC;
        CALC:    if (last_iter) state_d = FIX;
        FIX:                    state_d = DONE;
        DONE:    if (ready_i)   state_d = IDLE;
        default:                state_d = IDLE;
      endcase
    end
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    ready_o = (state_q == IDLE);
    valid_o = (state_q == DONE);
    busy_o  = (state_q != IDLE);
  end

  // ---------------- Datapath ----------------
  // MULHU treats both operands as unsigned; MULHSU only a is signed.
  assign sign_a = operand_a_i[WIDTH-1] & (func_i != FN_MULHU);
  assign sign_b = operand_b_i[WIDTH-1] & ~func_i[1];

  always_comb begin
    partial = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (b_mag_q[i]) partial = partial + ({{WIDTH{1'b0}}, a_mag_q} << i);
    end
    addend     = partial << (int'(count_q) * BITS_PER_CYCLE);
    final_prod = neg_q ? ('0 - product_q) : product_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: datapath registers are reset too, so result_o and the internal
    // magnitudes/product come up as a defined 0 rather than X.
    if (!rst_ni) begin
      func_q    <= FN_MUL;
      neg_q     <= 1'b0;
      a_mag_q   <= '0;
      b_mag_q   <= '0;
      product_q <= '0;
      count_q   <= '0;
      result_q  <= '0;
    end else if (!kill_i) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      unique case (state_q)
        IDLE: if (valid_i) begin
          func_q    <= func_e'(func_i);
          neg_q     <= sign_a ^ sign_b;
          a_mag_q   <= sign_a ? (WIDTH'(0) - operand_a_i) : operand_a_i;
          b_mag_q   <= sign_b ? (WIDTH'(0) - operand_b_i) : operand_b_i;
          product_q <= '0;
          count_q   <= '0;
        end
        CALC: begin
          product_q <= product_q + addend;
          b_mag_q   <= b_mag_q >> BITS_PER_CYCLE;
          count_q   <= count_q + CNT_W'(1);
        end
        FIX: result_q <= (func_q == FN_MUL) ? final_prod[WIDTH-1:0]
                                            : final_prod[PW-1:WIDTH];
        default: ;
      endcase
    end
  end

  assign result_o = result_q;

endmodule

// File: tb/tb_mul_iter.sv
// Self-checking bench for mul_iter: directed vector table, kill/stall/reset
// sequences, and a randomized sweep over five WIDTH/BITS_PER_CYCLE configs.
module tb_mul_iter;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        valid_i, ready_i, kill_i;
  logic        ready_o, valid_o, busy_o;
  logic [31:0] operand_a_i, operand_b_i, result_o;
  logic [1:0]  func_i;

  int errors = 0;
  int checks = 0;
  bit sweep_go = 1'b0;
  int sweep_done_cnt = 0;

  always #5 clk_i = ~clk_i;

  mul_iter u_dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .operand_a_i (operand_a_i),
    .operand_b_i (operand_b_i),
    .func_i      (func_i),
    .kill_i      (kill_i),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .result_o    (result_o),
    .busy_o      (busy_o)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain signed/unsigned 64-bit arithmetic on the w-bit operands.
  function automatic logic [31:0] ref_mul(input int w, input logic [1:0] f,
                                          input logic [31:0] a, input logic [31:0] b);
    longint av, bv, p, mask;
    av = longint'(a);
    bv = longint'(b);
    if (f != 2'b10 && a[w-1]) av = av - (longint'(1) << w);
    if (f[1] == 1'b0 && b[w-1]) bv = bv - (longint'(1) << w);
    p    = av * bv;
    mask = (longint'(1) << w) - 1;
    if (f == 2'b00) return 32'(p & mask);
    return 32'((p >> w) & mask);
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // One full transaction on the main DUT: accept, scramble inputs during CALC,
  // measure latency, hold in DONE for 'hold' cycles, then hand off.
  task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] f, input logic [31:0] exp, input int hold);
    int   lat;
    logic busy_ok, stable_ok;
    check({name, " ready_o before accept"}, 64'(ready_o), 64'd1);
    valid_i = 1'b1; operand_a_i = a; operand_b_i = b; func_i = f;
    step();
    valid_i = 1'b0; operand_a_i = $urandom; operand_b_i = $urandom; func_i = 2'($urandom);
    lat = 0; busy_ok = 1'b1;
    while (!valid_o && lat < 100) begin
      if (ready_o || !busy_o) busy_ok = 1'b0;
      if (lat == 3) begin operand_a_i = ~a; func_i = ~f; end
      step();
      lat++;
    end
    check({name, " latency"}, 64'(lat), 64'd33);
    check({name, " ready_o low while busy"}, 64'(busy_ok), 64'd1);
    check({name, " result"}, 64'(result_o), 64'(exp));
    stable_ok = 1'b1;
    for (int i = 0; i < hold; i++) begin
      step();
      if (!valid_o || result_o !== exp) stable_ok = 1'b0;
    end
    check({name, " held under back-pressure"}, 64'(stable_ok), 64'd1);
    ready_i = 1'b1;
    step();
    ready_i = 1'b0;
    check({name, " post-handshake valid/ready/busy"}, 64'({valid_o, ready_o, busy_o}), 64'b010);
  endtask

  // Watch for n cycles that no result appears on the main DUT.
  task automatic expect_quiet(input string name, input int n);
    logic quiet;
    quiet = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (valid_o || busy_o) quiet = 1'b0;
      step();
    end
    check({name, " no result delivered"}, 64'(quiet), 64'd1);
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  f;
    logic [31:0] exp;
    int          hold;
  } vec_t;

  vec_t vecs[9];

  // ---------------- Randomized parameter sweep ----------------
  for (genvar g = 0; g < 5; g++) begin : g_sweep
    localparam int W = (g == 4) ? 16 : 32;
    localparam int B = (g == 4) ? 1 : (1 << g);
    localparam int N = W / B;

    logic         v, r, k, vo, ro, bo;
    logic [W-1:0] a, b, res;
    logic [1:0]   f;

    mul_iter #(.WIDTH(W), .BITS_PER_CYCLE(B)) u_sweep (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .valid_i     (v),
      .ready_o     (ro),
      .operand_a_i (a),
      .operand_b_i (b),
      .func_i      (f),
      .kill_i      (k),
      .valid_o     (vo),
      .ready_i     (r),
      .result_o    (res),
      .busy_o      (bo)
    );

    initial begin
      v = 1'b0; r = 1'b0; k = 1'b0; a = '0; b = '0; f = '0;
      wait (sweep_go);
      for (int i = 0; i < 1000; i++) begin
        logic [W-1:0] ta, tb_op, exp;
        logic [1:0]   tf;
        int           lat;
        ta    = W'($urandom);
        tb_op = W'($urandom);
        tf    = 2'($urandom);
        if ($urandom_range(0, 7) == 0) ta    = {1'b1, {(W-1){1'b0}}};
        if ($urandom_range(0, 7) == 0) tb_op = '1;
        exp = W'(ref_mul(W, tf, 32'(ta), 32'(tb_op)));
        step();
        check($sformatf("sweep%0d[%0d] ready_o", g, i), 64'(ro), 64'd1);
        v = 1'b1; a = ta; b = tb_op; f = tf;
        step();
        v = 1'b0; a = W'($urandom); b = W'($urandom); f = 2'($urandom);
        lat = 0;
        while (!vo && lat < 200) begin
          step();
          lat++;
        end
        check($sformatf("sweep%0d[%0d] latency", g, i), 64'(lat), 64'(N + 1));
        check($sformatf("sweep%0d[%0d] result f=%0d a=%0h b=%0h", g, i, tf, ta, tb_op),
              64'(res), 64'(exp));
        repeat ($urandom_range(0, 2)) step();
        r = 1'b1;
        step();
        r = 1'b0;
      end
      sweep_done_cnt++;
    end
  end

  // ---------------- Directed test ----------------
  initial begin
    int t;
    valid_i = 1'b0; ready_i = 1'b0; kill_i = 1'b0;
    operand_a_i = '0; operand_b_i = '0; func_i = 2'b00;
    rst_ni = 1'b0;
    #1;
    check("reset ready/valid/busy", 64'({ready_o, valid_o, busy_o}), 64'b100);
    check("reset result_o", 64'(result_o), 64'd0);
    repeat (2) @(posedge clk_i);
    #2 rst_ni = 1'b1;
    step();

    vecs[0] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00, 32'h0000_0001, 0};
    vecs[1] = '{32'h8000_0000, 32'h8000_0000, 2'b01, 32'h4000_0000, 0};
    vecs[2] = '{32'h8000_0000, 32'h0000_0001, 2'b01, 32'hFFFF_FFFF, 0};
    vecs[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b10, 32'hFFFF_FFFE, 0};
    vecs[4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b11, 32'hFFFF_FFFF, 10};
    vecs[5] = '{32'h0000_0002, 32'h8000_0000, 2'b11, 32'h0000_0001, 0};
    vecs[6] = '{32'h8000_0000, 32'h0000_0002, 2'b10, 32'h0000_0001, 3};
    vecs[7] = '{32'h1234_5678, 32'h0000_0000, 2'b00, 32'h0000_0000, 0};
    vecs[8] = '{32'h0001_0000, 32'h0001_0003, 2'b00, 32'h0003_0000, 1};

    for (int i = 0; i < 9; i++)
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].f, vecs[i].exp, vecs[i].hold);

    // kill in CALC: unit returns to IDLE, last result kept.
    valid_i = 1'b1; operand_a_i = 32'd9; operand_b_i = 32'd9; func_i = 2'b00;
    step();
    valid_i = 1'b0;
    repeat (5) step();
    kill_i = 1'b1;
    step();
    kill_i = 1'b0;
    check("kill CALC valid/ready/busy", 64'({valid_o, ready_o, busy_o}), 64'b010);
    check("kill CALC result kept", 64'(result_o), 64'h0003_0000);
    expect_quiet("kill CALC", 40);

    // kill together with a request: nothing accepted.
    valid_i = 1'b1; kill_i = 1'b1; operand_a_i = 32'd4; operand_b_i = 32'd4;
    step();
    valid_i = 1'b0; kill_i = 1'b0;
    check("kill accept valid/ready/busy", 64'({valid_o, ready_o, busy_o}), 64'b010);
    expect_quiet("kill accept", 40);

    // kill in DONE with ready_i: result register keeps the computed product.
    valid_i = 1'b1; operand_a_i = 32'd5; operand_b_i = 32'd6; func_i = 2'b00;
    step();
    valid_i = 1'b0;
    t = 0;
    while (!valid_o && t < 100) begin step(); t++; end
    check("kill DONE reached DONE", 64'(valid_o), 64'd1);
    ready_i = 1'b1; kill_i = 1'b1;
    step();
    ready_i = 1'b0; kill_i = 1'b0;
    check("kill DONE valid/ready/busy", 64'({valid_o, ready_o, busy_o}), 64'b010);
    check("kill DONE result kept", 64'(result_o), 64'd30);

    run_op("mul 7*-3", 32'd7, 32'hFFFF_FFFD, 2'b00, 32'hFFFF_FFEB, 0);

    // Asynchronous reset mid-CALC.
    valid_i = 1'b1; operand_a_i = 32'h1234; operand_b_i = 32'h5678; func_i = 2'b00;
    step();
    valid_i = 1'b0;
    repeat (5) step();
    rst_ni = 1'b0;
    #1;
    check("async reset valid/ready/busy", 64'({valid_o, ready_o, busy_o}), 64'b010);
    check("async reset result_o", 64'(result_o), 64'd0);
    #2 rst_ni = 1'b1;
    step();
    check("after reset ready_o", 64'(ready_o), 64'd1);
    run_op("post-reset mulhu", 32'h0001_0000, 32'h0001_0000, 2'b10, 32'h0000_0001, 0);

    sweep_go = 1'b1;
    t = 0;
    while (sweep_done_cnt < 5 && t < 80000) begin
      @(posedge clk_i);
      t++;
    end
    check("sweep completed", 64'(sweep_done_cnt), 64'd5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mul_iter.md
# mul_iter

Parametrised iterative integer multiplier for the RV32M execute stage. It implements MUL, MULH, MULHU and MULHSU with a valid/ready handshake on both sides and a configurable number of multiplier bits retired per cycle (radix). Operands and the operation are latched at acceptance, so the pipeline may change its inputs freely afterwards. A kill input lets the pipeline abandon an in-flight operation on flush.

## Interface
- WIDTH, 32: operand and result width; must be ≥ 8 and even.
- BITS_PER_CYCLE, 1: multiplier bits consumed per CALC cycle; must divide WIDTH. Legal values are 1, 2, 4 and 8. An illegal value is an elaboration error.

- clk_i  in  1  clock; all state changes on the rising edge.
- rst_ni  in  1  reset; asynchronous, active-low.
- valid_i  in  1  request valid.
- ready_o  out  1  unit can accept a request (high only in IDLE).
- operand_a_i  in  WIDTH  multiplicand (rs1).
- operand_b_i  in  WIDTH  multiplier (rs2).
- func_i  in  2  operation: 00 MUL, 01 MULH, 10 MULHU, 11 MULHSU.
- kill_i  in  1  synchronous abort of any in-flight or pending request.
- valid_o  out  1  result valid; held until accepted.
- ready_i  in  1  consumer accepts the result.
- result_o  out  WIDTH  registered result; stable while valid_o is high.
- busy_o  out  1  high in CALC, FIX and DONE.

## Operation
- The block has four states: IDLE, CALC, FIX and DONE. Reset enters IDLE.
- **Reset values:** ready_o=1, valid_o=0, busy_o=0, result_o=0. Internal product, magnitudes and counter are all 0.
- **IDLE**
  - Accept occurs when valid_i=1, ready_o=1 and kill_i=0.
  - On accept, register the following:
    - sign_a = operand_a_i[MSB] for func 00, 01 and 11; otherwise 0.
    - sign_b = operand_b_i[MSB] for func 00 and 01; otherwise 0.
    - a_mag = sign_a ? −a : a, and b_mag = sign_b ? −b : b. Both are WIDTH-bit unsigned, so the most negative value maps to 2^(WIDTH−1).
    - neg = sign_a ^ sign_b, and func_i.
  - Also on accept: product=0, count=0, then go to CALC.
- **CALC**
  - Each cycle: product += (a_mag × b_mag[BITS_PER_CYCLE−1:0]), zero-extended to 2·WIDTH and shifted left by count·BITS_PER_CYCLE.
  - Then b_mag >>= BITS_PER_CYCLE and count += 1.
  - After N = WIDTH/BITS_PER_CYCLE iterations, go to FIX.
  - The product register is 2·WIDTH bits and must never overflow.
- **FIX**
  - final = neg ? −product : product, taken mod 2^(2·WIDTH).
  - result_o ← final[WIDTH−1:0] for MUL; final[2·WIDTH−1:WIDTH] for all other ops.
  - Go to DONE.
- **DONE**
  - valid_o=1 and result_o is held.
  - When ready_i=1: go to IDLE, and valid_o drops on the next edge.
- **kill_i**
  - In any state, kill_i=1 sends the block to IDLE on the next edge and clears valid_o and busy_o.
  - result_o keeps its last value, and no result is delivered for the killed op.
  - kill_i has priority over valid_i and over ready_i.
- **Input stability:** operand_a_i, operand_b_i and func_i are ignored outside the accept cycle.
- **Asynchronous reset mid-operation:** returns immediately to the reset values. The in-flight op is lost.

## Timing
- Request accepted at edge k (CALC entered) → valid_o high after edge k+N+1.
- Cycles from accept to valid_o:
  - 33 for WIDTH=32, BITS_PER_CYCLE=1.
  - 17 for BITS_PER_CYCLE=2.
  - 9 for BITS_PER_CYCLE=4.
  - 5 for BITS_PER_CYCLE=8.
- Latency is independent of operand values and func_i; there is no early-out.
- ready_o is combinational from state (IDLE). valid_o and busy_o are decoded from registered state. result_o is a register.
- Back-to-back throughput: a result accepted at edge j lets the next request be accepted at edge j+1 at the earliest, since ready_o rises after edge j.
- A result held with ready_i=0 stalls the unit indefinitely, with no loss.

## Test plan
- **Reset, then MUL:** −1 × −1 (0xFFFFFFFF, 0xFFFFFFFF, func 00), BITS_PER_CYCLE=1 → result_o=0x00000001, valid_o exactly 33 cycles after accept, ready_o low throughout.
- **MULH extreme:** 0x80000000 × 0x80000000 → 0x40000000. MULH 0x80000000 × 0x00000001 → 0xFFFFFFFF.
- **MULHU / MULHSU:**
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU a=0xFFFFFFFF (−1), b=0xFFFFFFFF → 0xFFFFFFFF.
  - MULHSU a=2, b=0x80000000 → 0x00000001.
- **Back-pressure and changing inputs:** hold ready_i=0 for 10 cycles in DONE; change operand_a_i and func_i during CALC → result unchanged and stable, valid_o held. Release → next request accepted the cycle after the result handshake.
- **kill_i:** assert kill_i in CALC, assert kill_i during the accept cycle, and assert kill_i in DONE together with ready_i → no valid_o for those ops; ready_o=1 after the next edge. A following MUL 7 × −3 returns 0xFFFFFFEB.
- **Parameter sweep:** 1000 random operand/func vectors against a 64-bit reference model for BITS_PER_CYCLE ∈ {1,2,4,8} at WIDTH=32, plus WIDTH=16 → all match, with latency N+1. An async reset pulse mid-CALC gives reset values immediately.
